data_mem: RTL and testbench

- Small byte-addressed data memory for the single-cycle MIPS datapath (load/store stage).
- Holds 2**ADDR_W bytes and exposes 32-bit big-endian word access at any byte address, aligned or not.
- Addresses wrap modulo memory size.
- Reads are combinational; writes commit on the clock edge.

---
 rtl/data_mem_pkg.sv | 18 +
 rtl/data_mem_word_gather.sv | 21 ++
 rtl/data_mem.sv | 55 +++++
 tb/tb_data_mem.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_pkg.sv
// Shared constants and helpers for the byte-addressed data memory.
// Byte-index wrap and reset pattern live here so the read and write paths agree.
package data_mem_pkg;

    localparam int ADDR_W_DEF     = 4;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic [7:0] resetByte(input int unsigned idx);
        return idx[7:0];
    endfunction

    function automatic int unsigned wrapIndex(input int unsigned base,
                                              input int unsigned lane,
                                              input int unsigned addrW);
        return (base + lane) & ((32'd1 << addrW) - 32'd1);
    endfunction

endpackage

// File: rtl/data_mem_word_gather.sv
// Combinational big-endian gather of four consecutive bytes, wrapping at the top of memory.
module data_mem_word_gather
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [7:0]        bytes_i [2**ADDR_W],
    input  logic [ADDR_W-1:0] byte_addr_i,
    output logic [31:0]       word_o
);

    // Lane 0 is the most-significant byte and sits at the base address.
    always_comb begin
        word_o = '0;
        for (int unsigned lane = 0; lane < BYTES_PER_WORD; lane++) begin
            word_o[31-8*lane -: 8] =
                bytes_i[ADDR_W'(wrapIndex(32'(byte_addr_i), lane, ADDR_W))];
        end
    end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed data memory with 32-bit big-endian word access at any byte address.
// Reads are combinational; writes commit on the rising clock edge.
module data_mem
    import data_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-1:0] out,
    input  logic [ADDR_W-1:0] byte_addr,
    input  logic [DATA_W-1:0] data_i,
    input  logic              e_read,
    input  logic              e_write
);

    localparam int DEPTH = 2**ADDR_W;

    logic [7:0]  memQ [DEPTH];
    logic [7:0]  memD [DEPTH];
    logic [31:0] gatheredWord;

    // Write-lane decode mirrors the read gather: lane 0 takes the top byte.
    always_comb begin
        memD = memQ;
        if (e_write) begin
            for (int unsigned lane = 0; lane < BYTES_PER_WORD; lane++) begin
                memD[ADDR_W'(wrapIndex(32'(byte_addr), lane, ADDR_W))] =
                    data_i[31-8*lane -: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                memQ[i] <= resetByte(i);
            end
        end else begin
            memQ <= memD;
        end
    end

    data_mem_word_gather #(
        .ADDR_W(ADDR_W)
    ) u_gather (
        .bytes_i    (memQ),
        .byte_addr_i(byte_addr),
        .word_o     (gatheredWord)
    );

    assign out = e_read ? DATA_W'(gatheredWord) : '0;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem against a byte-array reference model.
module tb_data_mem;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk;
    logic              rst_n;
    logic [31:0]       out;
    logic [ADDR_W-1:0] byte_addr;
    logic [31:0]       data_i;
    logic              e_read;
    logic              e_write;

    int compared;
    int mismatched;

    logic [7:0] refMem [DEPTH];

    data_mem #(
        .ADDR_W(ADDR_W),
        .DATA_W(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .out      (out),
        .byte_addr(byte_addr),
        .data_i   (data_i),
        .e_read   (e_read),
        .e_write  (e_write)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] refWord(input int a);
        return {refMem[a % DEPTH], refMem[(a + 1) % DEPTH],
                refMem[(a + 2) % DEPTH], refMem[(a + 3) % DEPTH]};
    endfunction

    function automatic logic [31:0] refRead(input int a, input logic rd);
        return rd ? refWord(a) : 32'h0;
    endfunction

    task automatic refReset();
        for (int i = 0; i < DEPTH; i++) refMem[i] = 8'(i);
    endtask

    task automatic refWrite(input int a, input logic [31:0] d);
        refMem[a % DEPTH]       = d[31:24];
        refMem[(a + 1) % DEPTH] = d[23:16];
        refMem[(a + 2) % DEPTH] = d[15:8];
        refMem[(a + 3) % DEPTH] = d[7:0];
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        refReset();
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        doReset();
        e_read = 1'b1;
        byte_addr = 4'd0;
        #1;
        exp = 32'h00010203;
        compared++;
        if (out !== exp) begin
            mismatched++;
            $display("[TB] FAIL reset_addr0: got %h expected %h", out, exp);
        end
        byte_addr = 4'd4;
        #1;
        exp = 32'h04050607;
        compared++;
        if (out !== exp) begin
            mismatched++;
            $display("[TB] FAIL reset_addr4: got %h expected %h", out, exp);
        end
    endtask

    task automatic test_wrap_read();
        logic [31:0] exp [3];
        exp[0] = 32'h0D0E0F00;
        exp[1] = 32'h0E0F0001;
        exp[2] = 32'h0F000102;
        e_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            byte_addr = 4'(13 + i);
            #1;
            compared++;
            if (out !== exp[i]) begin
                mismatched++;
                $display("[TB] FAIL wrap_read_addr%0d: got %h expected %h", 13 + i, out, exp[i]);
            end
            compared++;
            if (out !== refWord(13 + i)) begin
                mismatched++;
                $display("[TB] FAIL wrap_read_model_addr%0d: got %h expected %h", 13 + i, out, refWord(13 + i));
            end
        end
    endtask

    task automatic test_unaligned_write();
        @(negedge clk);
        e_write = 1'b1;
        byte_addr = 4'd5;
        data_i = 32'h1A2B3C4D;
        @(posedge clk);
        refWrite(5, 32'h1A2B3C4D);
        #1;
        e_write = 1'b0;
        e_read = 1'b1;
        for (int a = 4; a <= 7; a++) begin
            byte_addr = 4'(a);
            #1;
            compared++;
            if (out !== refWord(a)) begin
                mismatched++;
                $display("[TB] FAIL unaligned_write_addr%0d: got %h expected %h", a, out, refWord(a));
            end
        end
        byte_addr = 4'd5;
        #1;
        compared++;
        if (out !== 32'h1A2B3C4D) begin
            mismatched++;
            $display("[TB] FAIL unaligned_write_exact: got %h expected %h", out, 32'h1A2B3C4D);
        end
    endtask

    task automatic test_read_disable();
        doReset();
        e_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            byte_addr = 4'($urandom_range(0, DEPTH - 1));
            #1;
            compared++;
            if (out !== 32'h0) begin
                mismatched++;
                $display("[TB] FAIL read_disable_addr%0d: got %h expected %h", byte_addr, out, 32'h0);
            end
        end
        byte_addr = 4'd8;
        e_read = 1'b1;
        #0;
        #0;
        compared++;
        if (out !== 32'h08090A0B) begin
            mismatched++;
            $display("[TB] FAIL read_enable_addr8: got %h expected %h", out, 32'h08090A0B);
        end
    endtask

    task automatic test_rdw();
        @(negedge clk);
        e_read = 1'b1;
        e_write = 1'b1;
        byte_addr = 4'd5;
        data_i = 32'hDEADBEEF;
        #1;
        compared++;
        if (out !== 32'h05060708) begin
            mismatched++;
            $display("[TB] FAIL rdw_before_edge: got %h expected %h", out, 32'h05060708);
        end
        @(posedge clk);
        refWrite(5, 32'hDEADBEEF);
        #1;
        e_write = 1'b0;
        compared++;
        if (out !== 32'hDEADBEEF) begin
            mismatched++;
            $display("[TB] FAIL rdw_after_edge: got %h expected %h", out, 32'hDEADBEEF);
        end
    endtask

    task automatic test_wrapped_write();
        @(negedge clk);
        e_write = 1'b1;
        byte_addr = 4'd14;
        data_i = 32'hAABBCCDD;
        @(posedge clk);
        refWrite(14, 32'hAABBCCDD);
        #1;
        e_write = 1'b0;
        e_read = 1'b1;
        byte_addr = 4'd14;
        #1;
        compared++;
        if (out !== 32'hAABBCCDD) begin
            mismatched++;
            $display("[TB] FAIL wrapped_write_addr14: got %h expected %h", out, 32'hAABBCCDD);
        end
        byte_addr = 4'd0;
        #1;
        compared++;
        if (out !== 32'hCCDD0203) begin
            mismatched++;
            $display("[TB] FAIL wrapped_write_addr0: got %h expected %h", out, 32'hCCDD0203);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        refReset();
        e_read = 1'b1;
        byte_addr = 4'd5;
        #1;
        compared++;
        if (out !== 32'h05060708) begin
            mismatched++;
            $display("[TB] FAIL async_reset_immediate: got %h expected %h", out, 32'h05060708);
        end
        e_read = 1'b0;
        #1;
        compared++;
        if (out !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL async_reset_read_off: got %h expected %h", out, 32'h0);
        end
        e_write = 1'b1;
        data_i = $urandom;
        @(posedge clk);
        #1;
        e_read = 1'b1;
        #1;
        compared++;
        if (out !== 32'h05060708) begin
            mismatched++;
            $display("[TB] FAIL async_reset_write_ignored: got %h expected %h", out, 32'h05060708);
        end
        @(negedge clk);
        e_write = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int a;
        logic [31:0] d;
        logic rd;
        logic wr;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            a = int'($urandom_range(0, DEPTH - 1));
            d = $urandom;
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            byte_addr = 4'(a);
            data_i = d;
            e_read = rd;
            e_write = wr;
            #1;
            compared++;
            if (out !== refRead(a, rd)) begin
                mismatched++;
                $display("[TB] FAIL random_pre[%0d] addr%0d: got %h expected %h", n, a, out, refRead(a, rd));
            end
            @(posedge clk);
            if (wr) refWrite(a, d);
            #1;
            e_write = 1'b0;
            compared++;
            if (out !== refRead(a, rd)) begin
                mismatched++;
                $display("[TB] FAIL random_post[%0d] addr%0d: got %h expected %h", n, a, out, refRead(a, rd));
            end
            a = int'($urandom_range(0, DEPTH - 1));
            byte_addr = 4'(a);
            e_read = 1'b1;
            #1;
            compared++;
            if (out !== refWord(a)) begin
                mismatched++;
                $display("[TB] FAIL random_probe[%0d] addr%0d: got %h expected %h", n, a, out, refWord(a));
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst_n      = 1'b1;
        byte_addr  = '0;
        data_i     = '0;
        e_read     = 1'b0;
        e_write    = 1'b0;
        refReset();

        test_reset();
        test_wrap_read();
        test_unaligned_write();
        test_read_disable();
        test_rdw();
        test_wrapped_write();
        test_async_reset();
        test_random();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
